// File: rtl/guitar_pkg.sv
// guitar_pkg: shared envelope state encoding and audio constants for the voice stages
package guitar_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, DECAY = 2'd2} env_state_t;
    localparam logic [7:0] ENV_MAX = 8'd255;
    localparam logic [7:0] PWM_MID = 8'd128;
    localparam int CLK_MHZ = 25;
endpackage

// File: rtl/pwm_dac.sv
// pwm_dac: 8-bit free-running PWM, output high while the counter is below the sample
module pwm_dac (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample,
    output logic       pwm_out
);
    logic [7:0] pcnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pcnt    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pcnt    <= pcnt + 8'd1;
            pwm_out <= pcnt < sample;
        end
endmodule

// File: rtl/pluck_envelope.sv
// pluck_envelope: plucked-string attack/decay envelope applied to a square tone, PWM audio out.
// Define PLUCK_LINEAR_DECAY_EN for a constant 1-per-tick decay instead of the exponential one.
module pluck_envelope
    import guitar_pkg::*;
#(
    parameter int TICK_DIV    = 250000,
    parameter int ATTACK_STEP = 64,
    parameter int DECAY_SHIFT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strum,
    input  logic       tone_in,
    output logic       pwm_out,
    output logic [7:0] env_level,
    output logic       busy
);
    localparam int TW = $clog2(TICK_DIV);
    logic s1, s2, s3, strum_evt, tick;
    logic [TW-1:0] tcnt;
    env_state_t state;
    logic [7:0] env, sample, dec, half;
    logic [8:0] sum;
    assign env_level = env;
    always_comb begin
        strum_evt = s2 ^ s3;
        tick      = tcnt == TW'(TICK_DIV - 1);
        sum       = {1'b0, env} + 9'(ATTACK_STEP);
        half      = {1'b0, env[7:1]};
`ifdef PLUCK_LINEAR_DECAY_EN
        dec       = 8'd1;
`else
        dec       = (env >> DECAY_SHIFT) == 8'd0 ? 8'd1 : env >> DECAY_SHIFT;
`endif
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {s1, s2, s3} <= '0;
            tcnt         <= '0;
            state        <= IDLE;
            env          <= '0;
            busy         <= 1'b0;
            sample       <= '0;
        end else begin
            {s1, s2, s3} <= {strum, s1, s2};
            tcnt         <= tick ? '0 : tcnt + 1'b1;
            sample       <= tone_in ? PWM_MID + half : PWM_MID - half;
            // a strum edge retriggers from the current level and swallows a coincident tick
            if (strum_evt) begin
                state <= ATTACK;
                busy  <= 1'b1;
            end else if (tick)
                case (state)
                    ATTACK: begin
                        env <= sum[8] ? ENV_MAX : sum[7:0];
                        if (sum[8] || sum[7:0] == ENV_MAX) state <= DECAY;
                    end
                    DECAY:
                        if (dec >= env) begin
                            env   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else env <= env - dec;
                    default: ;
                endcase
        end
    pwm_dac u_dac (
        .clk    (clk),
        .reset  (reset),
        .sample (sample),
        .pwm_out(pwm_out)
    );
endmodule
